frame_source_scheduler: RTL and testbench
=========================================

Name: frame_source_scheduler

Overview:
- Sequences and arbitrates writes into the OLED driver's 1024-byte frame buffer update port.
- On each `buffer_update_request` pulse from the screen driver, it selects one of NUM_SRC pattern generators and starts that source's frame.
- It then streams exactly 1024 bytes from the selected source onto `buffer_update_addr`, `buffer_update_data` and `buffer_update_write`.
- The active source rotates every FRAMES_PER_SRC frames or on a `next_pattern` command. Stalled sources are blank-filled, and overlapping requests are counted as overruns.

Parameters:
- NUM_SRC, 4: number of pattern sources (2..8).
- FRAMES_PER_SRC, 16: completed frames before automatic rotation to the next enabled source; 0 disables auto-rotation.
- STALL_LIMIT, 255: consecutive cycles without `src_valid` during a stream before timeout blank-fill.
- FRAME_BYTES, 1024: bytes per frame; must equal the address span of the 10-bit port.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  asynchronous active-low reset.
- buffer_update_request  in  1  single-cycle frame request pulse from the screen driver.
- buffer_update_addr  out  10  frame buffer write address.
- buffer_update_data  out  8  frame buffer write data.
- buffer_update_write  out  1  write strobe, one byte per asserted cycle.
- src_enable  in  NUM_SRC  per-source enable mask, sampled at frame start.
- next_pattern  in  1  pulse that forces rotation at the next frame boundary.
- src_frame_start  out  NUM_SRC  one-hot single-cycle pulse to the selected source.
- src_valid  in  NUM_SRC  per-source byte-valid.
- src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
- src_ready  out  NUM_SRC  one-hot ready to the selected source, only while streaming.
- active_src  out  3  index of the current source.
- blank_mode  out  1  high while the frame is being filled with 0x00 because no source is enabled.
- frame_done  out  1  single-cycle pulse after the last byte is written.
- stall_err  out  1  sticky flag: a timeout occurred. Cleared only by reset.
- overrun_cnt  out  8  saturating count of requests received while not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; `active_src` is 0.
  - State is IDLE; byte counter, frame counter and stall counter are 0; `next_pending` is 0.
  - Reset mid-frame abandons the frame immediately. No further writes occur after reset asserts.
- States: IDLE -> START -> STREAM -> DONE -> IDLE.
- IDLE:
  - On `buffer_update_request`, sample `src_enable`.
  - If `src_enable` is 0, set `blank_mode` = 1.
  - Otherwise, if `src_enable[active_src]` = 0, move `active_src` to the next enabled index cyclically upward.
  - Go to START.
- START (1 cycle):
  - Pulse `src_frame_start[active_src]` unless in blank mode.
  - Clear the byte counter and stall counter. Go to STREAM.
- STREAM:
  - `src_ready[active_src]` = 1; all other ready bits are 0.
  - A byte is accepted when valid && ready. On the next cycle, `buffer_update_write` = 1, addr = byte counter, data = that byte (latency 1).
  - The byte counter increments per accepted byte.
  - In blank mode, one 0x00 byte is written per cycle without any handshake.
  - The stall counter increments on each ready cycle with valid=0 and resets on acceptance.
  - When the stall counter reaches STALL_LIMIT: set `stall_err`, drop ready, and write 0x00 to the remaining addresses, one per cycle.
  - After the byte at address 1023 has been accepted or filled, go to DONE. The counter must not wrap into a second pass.
- DONE (1 cycle):
  - Pulse `frame_done`, clear `blank_mode`, increment the frame counter.
  - Rotation occurs if `next_pending` is set, or if FRAMES_PER_SRC != 0 and frame counter = FRAMES_PER_SRC-1.
  - On rotation: `active_src` moves to the next enabled index greater than the current one, cyclically. If no other source is enabled it is unchanged. The frame counter and `next_pending` are cleared.
  - Return to IDLE.
- `next_pattern`: latched into `next_pending` in any state and consumed only in DONE.
- Request outside IDLE: ignored for sequencing. `overrun_cnt` increments and saturates at 255. A request in the DONE cycle is also an overrun.
- Output timing: `buffer_update_write` is never asserted in IDLE or START. Addresses within a frame are strictly 0..1023 ascending with no duplicates.

Decomposition:
- Shared package (oled_pkg):
  - FB_BYTES = 1024, FB_ADDR_W = 10.
  - State enum {IDLE, START, STREAM, DONE}.
  - Blank byte constant 8'h00.
- Sub-module: `rr_next_enabled`, combinational, returns the next enabled index above a given index with wrap-around and a `none` flag. Used in both IDLE and DONE.

Test Plan:
- Reset, enable = 4'b0001, one request, source 0 supplies bytes 0x00..0xFF repeating with valid always high:
  - 1024 writes, addr 0..1023, data = addr[7:0].
  - `frame_done` pulses 1 cycle after the write to addr 1023.
- FRAMES_PER_SRC = 2, enable = 4'b1011, 6 frames: `active_src` sequence is 0,0,1,1,3,3, and `src_frame_start` is one-hot each frame.
- enable = 0, one request:
  - `blank_mode` = 1 throughout the frame; 1024 writes of 0x00 in 1024 consecutive cycles.
  - `src_frame_start` is never asserted.
- Source 0 delivers 100 bytes, then holds valid low:
  - After 255 stall cycles, `stall_err` = 1 and addresses 100..1023 are written with 0x00.
  - `frame_done` follows.
- Request pulsed 3 times during STREAM: `overrun_cnt` = 3, the frame completes normally, and no restart occurs.
- rst_n deasserted at byte 500: outputs are 0 asynchronously. The next request restarts a frame at addr 0 with `active_src` = 0.

Source files
------------

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared frame buffer constants and scheduler state encoding
package oled_pkg;

  localparam int         FB_BYTES   = 1024;
  localparam int         FB_ADDR_W  = 10;
  localparam logic [7:0] BLANK_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/frame_source_scheduler_rr_next_enabled.sv
// rtl/frame_source_scheduler_rr_next_enabled.sv - next enabled source index above a given one, with wrap
module rr_next_enabled #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [2:0]   idx,
  output logic [2:0]   next_idx,
  output logic         none
);

  // Scan downward in distance so the closest enabled index above idx wins;
  // idx itself is never a candidate, so a lone enabled source reports none.
  always_comb begin
    int c;
    c        = 0;
    next_idx = idx;
    none     = 1'b1;
    for (int k = N - 1; k >= 1; k--) begin
      c = (int'(idx) + k) % N;
      if (mask[c]) begin
        next_idx = 3'(c);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_source_scheduler.sv
// rtl/frame_source_scheduler.sv - arbitrates pattern sources into the OLED frame buffer update port
module frame_source_scheduler
  import oled_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int FRAMES_PER_SRC = 16,
  parameter int STALL_LIMIT    = 255,
  parameter int FRAME_BYTES    = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   buffer_update_request,
  output logic [9:0]             buffer_update_addr,
  output logic [7:0]             buffer_update_data,
  output logic                   buffer_update_write,
  input  logic [NUM_SRC-1:0]     src_enable,
  input  logic                   next_pattern,
  output logic [NUM_SRC-1:0]     src_frame_start,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [2:0]             active_src,
  output logic                   blank_mode,
  output logic                   frame_done,
  output logic                   stall_err,
  output logic [7:0]             overrun_cnt
);

  localparam int SC_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam int FC_W = (FRAMES_PER_SRC < 2) ? 1 : $clog2(FRAMES_PER_SRC + 1);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_BYTES - 1);

  state_t               state_q, state_d;
  logic [FB_ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [SC_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                 next_pending_q, next_pending_d;
  logic [2:0]           active_src_q, active_src_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic                 blank_mode_q, blank_mode_d;
  logic                 timeout_q, timeout_d;
  logic                 stall_err_q, stall_err_d;
  logic [7:0]           overrun_q, overrun_d;
  logic                 wr_q, wr_d;
  logic [9:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic                 frame_done_q, frame_done_d;

  logic [NUM_SRC-1:0]   sel_onehot;
  logic [NUM_SRC-1:0]   rr_mask;
  logic [2:0]           rr_next;
  logic                 rr_none;
  logic                 sel_valid;
  logic [7:0]           sel_byte;
  logic                 filling;
  logic                 rotate;

  assign sel_onehot = NUM_SRC'(1) << active_src_q;
  // IDLE looks at the live mask being sampled; DONE uses the mask latched for this frame.
  assign rr_mask    = (state_q == IDLE) ? src_enable : enable_q;
  assign filling    = blank_mode_q | timeout_q;

  rr_next_enabled #(.N(NUM_SRC)) u_rr (
    .mask     (rr_mask),
    .idx      (active_src_q),
    .next_idx (rr_next),
    .none     (rr_none)
  );

  // Mux the selected source's valid and byte out of the packed buses.
  always_comb begin
    sel_byte  = 8'h00;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_onehot[i]) begin
        sel_byte  = src_data[8*i +: 8];
        sel_valid = src_valid[i];
      end
    end
  end

  // Frame sequencing, byte handshake, stall timeout and rotation decisions.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    next_pending_d = next_pending_q | next_pattern;
    active_src_d   = active_src_q;
    enable_d       = enable_q;
    blank_mode_d   = blank_mode_q;
    timeout_d      = timeout_q;
    stall_err_d    = stall_err_q;
    overrun_d      = overrun_q;
    wr_d           = 1'b0;
    addr_d         = addr_q;
    data_d         = data_q;
    frame_done_d   = (state_q == DONE);
    rotate         = 1'b0;

    if (buffer_update_request && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (buffer_update_request) begin
          enable_d = src_enable;
          if (src_enable == '0) begin
            blank_mode_d = 1'b1;
          end else if (((src_enable & sel_onehot) == '0) && !rr_none) begin
            active_src_d = rr_next;
          end
          state_d = START;
        end
      end
      START: begin
        byte_cnt_d  = '0;
        stall_cnt_d = '0;
        timeout_d   = 1'b0;
        state_d     = STREAM;
      end
      STREAM: begin
        if (filling || sel_valid) begin
          wr_d        = 1'b1;
          addr_d      = byte_cnt_q;
          data_d      = filling ? BLANK_BYTE : sel_byte;
          byte_cnt_d  = byte_cnt_q + FB_ADDR_W'(1);
          stall_cnt_d = '0;
          if (byte_cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end
        end else begin
          stall_cnt_d = stall_cnt_q + SC_W'(1);
          if (int'(stall_cnt_q) + 1 >= STALL_LIMIT) begin
            timeout_d   = 1'b1;
            stall_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        blank_mode_d = 1'b0;
        timeout_d    = 1'b0;
        frame_cnt_d  = frame_cnt_q + FC_W'(1);
        rotate = next_pending_q ||
                 ((FRAMES_PER_SRC != 0) && (int'(frame_cnt_q) == FRAMES_PER_SRC - 1));
        if (rotate) begin
          frame_cnt_d    = '0;
          // A pulse landing in this very cycle still counts toward the next frame.
          next_pending_d = next_pattern;
          if (!rr_none) begin
            active_src_d = rr_next;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      byte_cnt_q     <= '0;
      stall_cnt_q    <= '0;
      frame_cnt_q    <= '0;
      next_pending_q <= 1'b0;
      active_src_q   <= 3'd0;
      enable_q       <= '0;
      blank_mode_q   <= 1'b0;
      timeout_q      <= 1'b0;
      stall_err_q    <= 1'b0;
      overrun_q      <= 8'd0;
      wr_q           <= 1'b0;
      addr_q         <= 10'd0;
      data_q         <= 8'd0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      next_pending_q <= next_pending_d;
      active_src_q   <= active_src_d;
      enable_q       <= enable_d;
      blank_mode_q   <= blank_mode_d;
      timeout_q      <= timeout_d;
      stall_err_q    <= stall_err_d;
      overrun_q      <= overrun_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign buffer_update_write = wr_q;
  assign buffer_update_addr  = addr_q;
  assign buffer_update_data  = data_q;
  assign src_frame_start     = ((state_q == START) && !blank_mode_q) ? sel_onehot : '0;
  assign src_ready           = ((state_q == STREAM) && !filling) ? sel_onehot : '0;
  assign active_src          = active_src_q;
  assign blank_mode          = blank_mode_q;
  assign frame_done          = frame_done_q;
  assign stall_err           = stall_err_q;
  assign overrun_cnt         = overrun_q;

endmodule

// File: tb/tb_frame_source_scheduler.sv
// tb/tb_frame_source_scheduler.sv - directed self-checking bench for frame_source_scheduler
module tb_frame_source_scheduler;

  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic            next_pattern = 1'b0;
  logic [NS-1:0]   src_enable = '0;
  logic [9:0]      addr;
  logic [7:0]      data;
  logic            wr;
  logic [NS-1:0]   fs;
  logic [NS-1:0]   src_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_ready;
  logic [2:0]      active;
  logic            blank;
  logic            done;
  logic            serr;
  logic [7:0]      ovr;

  frame_source_scheduler #(
    .NUM_SRC(NS), .FRAMES_PER_SRC(2), .STALL_LIMIT(255), .FRAME_BYTES(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buffer_update_request(req),
    .buffer_update_addr(addr), .buffer_update_data(data), .buffer_update_write(wr),
    .src_enable(src_enable), .next_pattern(next_pattern), .src_frame_start(fs),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .active_src(active), .blank_mode(blank), .frame_done(done),
    .stall_err(serr), .overrun_cnt(ovr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source model: byte value is its own per-frame count plus 16*index; goes quiet after stall_after bytes.
  int scnt [NS];
  int stall_after = 100000;
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (fs[i]) scnt[i] <= 0;
      else if (src_valid[i] && src_ready[i]) scnt[i] <= scnt[i] + 1;
    end
  end
  for (genvar g = 0; g < NS; g++) begin : g_src
    assign src_valid[g]        = (scnt[g] < stall_after);
    assign src_data[8*g +: 8]  = 8'(scnt[g]) + 8'(16 * g);
  end

  // Monitor: cumulative write/pulse statistics sampled on the falling edge.
  int exp_src = 0;
  int fill_from = 2000;
  int wr_total = 0, addr_err = 0, data_err = 0, nonblank_wr = 0, wr_in_rst = 0;
  int fs_total = 0, fs_bad = 0, done_total = 0, done_gap = -1;
  int c_a0 = 0, c_a99 = 0, c_a100 = 0, c_a1023 = 0;
  int exp_next = 0;
  logic [NS-1:0] fs_last = '0;
  logic [7:0] exp_byte;
  always @(negedge clk) begin
    if (!rst_n) exp_next = 0;
    if (wr) begin
      wr_total++;
      if (!rst_n) wr_in_rst++;
      if (int'(addr) != exp_next) addr_err++;
      exp_next = (addr == 10'd1023) ? 0 : int'(addr) + 1;
      exp_byte = (int'(addr) >= fill_from) ? 8'h00 : 8'(int'(addr) + 16 * exp_src);
      if (data !== exp_byte) data_err++;
      if (!blank) nonblank_wr++;
      if (addr == 10'd0)    c_a0 = cyc;
      if (addr == 10'd99)   c_a99 = cyc;
      if (addr == 10'd100)  c_a100 = cyc;
      if (addr == 10'd1023) c_a1023 = cyc;
    end
    if (fs != '0) begin
      fs_total++;
      fs_last = fs;
      if (!$onehot(fs)) fs_bad++;
    end
    if (done) begin
      done_total++;
      done_gap = cyc - c_a1023;
    end
  end

  int b_wr, b_aerr, b_derr, b_nb, b_fs, b_fsbad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = wr_total; b_aerr = addr_err; b_derr = data_err;
    b_nb = nonblank_wr; b_fs = fs_total; b_fsbad = fs_bad;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_total == base && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (done_total == base) check("frame_timeout", 0, 1);
  endtask

  task automatic run_frame();
    int base;
    base = done_total;
    pulse_req();
    wait_done(base);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_checks(input string tag, input int exp_fs);
    check({tag, "_writes"}, wr_total - b_wr, 1024);
    check({tag, "_addr_err"}, addr_err - b_aerr, 0);
    check({tag, "_data_err"}, data_err - b_derr, 0);
    check({tag, "_start_pulses"}, fs_total - b_fs, exp_fs);
  endtask

  int rot_seq [6] = '{0, 0, 1, 1, 3, 3};
  int base_d;
  int n;
  int wr_hold;
  int fs_hold;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_write", wr, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_active", active, 0);
    check("rst_ready", src_ready, 0);
    check("rst_done", done, 0);
    check("rst_misc", {blank, serr, ovr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single source 0, counting data, frame_done one cycle after last write
    src_enable = 4'b0001; exp_src = 0; fill_from = 2000;
    snap(); run_frame();
    frame_checks("basic", 1);
    check("basic_fs_sel", fs_last, 4'b0001);
    check("basic_done_gap", done_gap, 1);
    check("basic_active", active, 0);

    // Rotation every 2 frames over enable 1011
    do_reset();
    src_enable = 4'b1011;
    for (int f = 0; f < 6; f++) begin
      exp_src = rot_seq[f];
      snap(); run_frame();
      frame_checks("rot", 1);
      check("rot_fs_sel", fs_last, 32'(1 << rot_seq[f]));
      check("rot_onehot", fs_bad - b_fsbad, 0);
    end
    check("rot_wrap_active", active, 0);

    // No source enabled: blank fill, no frame start
    src_enable = 4'b0000; fill_from = 0;
    snap(); run_frame();
    frame_checks("blank", 0);
    check("blank_nonblank_wr", nonblank_wr - b_nb, 0);
    check("blank_span", c_a1023 - c_a0, 1023);
    check("blank_cleared", blank, 0);
    check("blank_active", active, 0);

    // Source stalls after 100 bytes: timeout then zero fill
    check("pre_stall_err", serr, 0);
    src_enable = 4'b0001; exp_src = 0; fill_from = 100; stall_after = 100;
    snap(); run_frame();
    frame_checks("stall", 1);
    check("stall_err", serr, 1);
    check("stall_gap", c_a100 - c_a99, 256);
    check("stall_done_gap", done_gap, 1);
    stall_after = 100000; fill_from = 2000;

    // Three requests during the stream are overruns only
    snap();
    base_d = done_total;
    pulse_req();
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      repeat (10) @(negedge clk);
    end
    wait_done(base_d);
    frame_checks("ovr", 1);
    check("ovr_cnt", ovr, 3);
    wr_hold = wr_total; fs_hold = fs_total;
    repeat (30) @(negedge clk);
    check("ovr_no_restart_wr", wr_total - wr_hold, 0);
    check("ovr_no_restart_fs", fs_total - fs_hold, 0);

    // Reset in the middle of a frame from source 1
    src_enable = 4'b0010; exp_src = 1;
    pulse_req();
    n = 0;
    while (!(wr && addr == 10'd500) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_500", {31'd0, wr && addr == 10'd500}, 1);
    check("mid_active", active, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_write", wr, 0);
    check("arst_addr", addr, 0);
    check("arst_active", active, 0);
    check("arst_ready", src_ready, 0);
    check("arst_misc", {blank, serr, ovr, done}, 0);
    repeat (5) @(negedge clk);
    check("arst_no_writes", wr_in_rst, 0);
    rst_n = 1'b1;
    @(negedge clk);
    src_enable = 4'b0001; exp_src = 0;
    snap(); run_frame();
    frame_checks("restart", 1);
    check("restart_fs_sel", fs_last, 4'b0001);
    check("restart_active", active, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
